// File: rtl/updown_counter_mod_pkg.sv
// Shared types and constants for the up/down counter slice (package udc_pkg).
// Holds the limit-mode encoding and the default and maximum parameter values.
package udc_pkg;

  typedef enum logic {
    UDC_WRAP = 1'b0,
    UDC_SAT  = 1'b1
  } udc_mode_e;

  localparam int UDC_WIDTH_DEF    = 16;
  localparam int UDC_PRESCALE_DEF = 4;
  localparam int UDC_PRESCALE_MAX = 256;

  // Prescale count only reaches PRESCALE-1, so 256 still fits in 8 bits.
  localparam int UDC_PRE_CNT_W = $clog2(UDC_PRESCALE_MAX);

endpackage

// File: rtl/updown_counter_mod_if.sv
// Control, limit and status signals of the up/down counter, grouped as one bus.
// master drives the controls and observes status; slave is the counter side.
interface udc_if
  import udc_pkg::*;
#(
  parameter int WIDTH = UDC_WIDTH_DEF
) ();

  logic             ld_cnt;
  logic             updn_cnt;
  logic             count_enb;
  logic             mode;
  logic [WIDTH-1:0] max_val;
  logic             flag_clr;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             tc;
  logic             ovf;
  logic             unf;

  modport master (
    output ld_cnt, updn_cnt, count_enb, mode, max_val, flag_clr, data_in,
    input  data_out, tc, ovf, unf
  );

  modport slave (
    input  ld_cnt, updn_cnt, count_enb, mode, max_val, flag_clr, data_in,
    output data_out, tc, ovf, unf
  );

endinterface

// File: rtl/updown_counter_mod_prescaler.sv
// Step prescaler: tick is high on every PRESCALE-th enabled cycle, combinationally.
// Count holds while enb is low and returns to zero on clr or rst.
module udc_prescaler
  import udc_pkg::*;
#(
  parameter int PRESCALE = UDC_PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic enb,
  output logic tick
);

  localparam logic [UDC_PRE_CNT_W-1:0] LAST = UDC_PRE_CNT_W'(PRESCALE - 1);
  localparam logic [UDC_PRE_CNT_W-1:0] ONE  = UDC_PRE_CNT_W'(1);

  logic [UDC_PRE_CNT_W-1:0] cnt_q;

  assign tick = enb && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else if (enb) begin
      cnt_q <= cnt_q + ONE;
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter with load, wrap/saturate limits at 0..max_val, sticky ovf/unf and a tc pulse.
// One-cycle registered outputs; optional step prescaler under UDC_PRESCALER_EN.
module updown_counter_mod
  import udc_pkg::*;
#(
  parameter int WIDTH    = UDC_WIDTH_DEF,
  parameter int PRESCALE = UDC_PRESCALE_DEF
) (
  input logic  clk,
  input logic  rst,
  udc_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             tc_q;
  logic             ovf_q;
  logic             unf_q;
  logic             ovf_set;
  logic             unf_set;
  logic             load;
  logic             step_en;
  logic             tick;
  logic             step;
  logic             sat;

  assign load    = ~bus.ld_cnt;
  assign step_en = bus.ld_cnt & bus.count_enb;
  assign sat     = (udc_mode_e'(bus.mode) == UDC_SAT);

`ifdef UDC_PRESCALER_EN
  udc_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .enb  (step_en),
    .tick (tick)
  );
`else
  // Without the prescaler every enabled cycle steps and PRESCALE has no effect.
  logic unused_prescale;
  assign unused_prescale = (PRESCALE > 0);
  assign tick = 1'b1;
`endif

  assign step = step_en & tick;

  // Limits are detected by comparing before the +/-1 so data_out never overflows.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (load) begin
      cnt_d = (bus.data_in > bus.max_val) ? bus.max_val : bus.data_in;
    end else if (step) begin
      if (bus.updn_cnt) begin
        if (cnt_q >= bus.max_val) begin
          ovf_set = 1'b1;
          cnt_d   = sat ? bus.max_val : '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (cnt_q == '0) begin
          unf_set = 1'b1;
          cnt_d   = sat ? '0 : bus.max_val;
        end else if (cnt_q > bus.max_val) begin
          // max_val was lowered under the count: count-1 >= max_val, so clamp.
          cnt_d = bus.max_val;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= ovf_set | unf_set;
      ovf_q <= (ovf_q & ~bus.flag_clr) | ovf_set;
      unf_q <= (unf_q & ~bus.flag_clr) | unf_set;
    end
  end

  assign bus.data_out = cnt_q;
  assign bus.tc       = tc_q;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: directed scenarios plus random traffic against a behavioural model.
module tb_updown_counter_mod;
  import udc_pkg::*;

  localparam int W  = 16;
  localparam int PS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  udc_if #(.WIDTH(W)) bus ();

  updown_counter_mod #(.WIDTH(W), .PRESCALE(PS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned m_cnt = 0;
  bit          m_tc  = 0;
  bit          m_ovf = 0;
  bit          m_unf = 0;
  int unsigned m_pre = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input bit ld, input bit en, input bit up, input bit md,
                        input int unsigned mx, input int unsigned din, input bit fc);
    bus.ld_cnt    = ld;
    bus.count_enb = en;
    bus.updn_cnt  = up;
    bus.mode      = md;
    bus.max_val   = W'(mx);
    bus.data_in   = W'(din);
    bus.flag_clr  = fc;
  endtask

  // Behavioural model of one rising edge, from the inputs currently applied.
  task automatic model_edge();
    int unsigned mx, din;
    bit tick, ovf_ev, unf_ev;
    mx     = 32'(bus.max_val);
    din    = 32'(bus.data_in);
    ovf_ev = 0;
    unf_ev = 0;
    if (rst) begin
      m_cnt = 0; m_tc = 0; m_ovf = 0; m_unf = 0; m_pre = 0;
      return;
    end
    if (!bus.ld_cnt) begin
      m_cnt = (din < mx) ? din : mx;
      m_pre = 0;
    end else if (bus.count_enb) begin
`ifdef UDC_PRESCALER_EN
      m_pre++;
      tick = (m_pre == PS);
      if (tick) m_pre = 0;
`else
      tick = 1;
`endif
      if (tick) begin
        if (bus.updn_cnt) begin
          if (m_cnt >= mx) begin
            ovf_ev = 1;
            m_cnt  = bus.mode ? mx : 0;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end else begin
          if (m_cnt == 0) begin
            unf_ev = 1;
            m_cnt  = bus.mode ? 0 : mx;
          end else begin
            m_cnt = ((m_cnt - 1) < mx) ? (m_cnt - 1) : mx;
          end
        end
      end
    end
    m_tc  = ovf_ev || unf_ev;
    m_ovf = (m_ovf && !bus.flag_clr) || ovf_ev;
    m_unf = (m_unf && !bus.flag_clr) || unf_ev;
  endtask

  // One clock: update the model at the edge, compare away from the edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("m_cnt", 32'(bus.data_out), m_cnt);
    check("m_tc",  32'(bus.tc),       32'(m_tc));
    check("m_ovf", 32'(bus.ovf),      32'(m_ovf));
    check("m_unf", 32'(bus.unf),      32'(m_unf));
  endtask

  task automatic expect_out(input string tag, input int unsigned c, input bit t,
                            input bit o, input bit u);
    check({tag, "_cnt"}, 32'(bus.data_out), c);
    check({tag, "_tc"},  32'(bus.tc),       32'(t));
    check({tag, "_ovf"}, 32'(bus.ovf),      32'(o));
    check({tag, "_unf"}, 32'(bus.unf),      32'(u));
  endtask

  initial begin
    rst = 1'b1;
    set_in(1, 0, 1, 0, 9, 0, 0);
    cyc();
    expect_out("reset", 0, 0, 0, 0);
    rst = 1'b0;

`ifndef UDC_PRESCALER_EN
    // Wrap up through the limit.
    set_in(0, 0, 1, 0, 9, 5, 0);
    cyc();
    expect_out("load5", 5, 0, 0, 0);
    set_in(1, 1, 1, 0, 9, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      expect_out("wrap_up", 6 + i, 0, 0, 0);
    end
    cyc();
    expect_out("wrap_9to0", 0, 1, 1, 0);

    // Saturate at the top, flag clear racing a set event, then clear alone.
    set_in(0, 0, 1, 1, 9, 9, 1);
    cyc();
    expect_out("load9", 9, 0, 0, 0);
    set_in(1, 1, 1, 1, 9, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_out("sat_up", 9, 1, 1, 0);
    end
    set_in(1, 1, 1, 1, 9, 0, 1);
    cyc();
    expect_out("sat_clr_evt", 9, 1, 1, 0);
    set_in(1, 0, 1, 1, 9, 0, 1);
    cyc();
    expect_out("clr_alone", 9, 0, 0, 0);

    // Down through zero with a full-range limit.
    set_in(0, 0, 0, 0, 16'hFFFF, 0, 0);
    cyc();
    expect_out("load0", 0, 0, 0, 0);
    set_in(1, 1, 0, 0, 16'hFFFF, 0, 0);
    cyc();
    expect_out("wrap_dn", 16'hFFFF, 1, 0, 1);
    set_in(0, 0, 0, 1, 16'hFFFF, 0, 1);
    cyc();
    expect_out("load0b", 0, 0, 0, 0);
    set_in(1, 1, 0, 1, 16'hFFFF, 0, 0);
    cyc();
    expect_out("sat_dn", 0, 1, 0, 1);

    // Load clamp and a limit lowered under the count.
    set_in(0, 0, 1, 0, 9, 20, 1);
    cyc();
    expect_out("ld_clamp", 9, 0, 0, 0);
    set_in(0, 0, 1, 0, 9, 7, 0);
    cyc();
    expect_out("ld7", 7, 0, 0, 0);
    set_in(1, 1, 1, 0, 3, 0, 0);
    cyc();
    expect_out("max_lowered_up", 0, 1, 1, 0);
    set_in(0, 0, 1, 0, 9, 7, 1);
    cyc();
    expect_out("ld7b", 7, 0, 0, 0);
    set_in(1, 1, 0, 0, 3, 0, 0);
    cyc();
    expect_out("max_lowered_dn", 3, 0, 0, 0);

    // max_val of zero: every step is a limit event.
    set_in(1, 1, 1, 0, 0, 0, 0);
    cyc();
    expect_out("max0_up", 0, 1, 1, 0);
    set_in(1, 1, 0, 0, 0, 0, 0);
    cyc();
    expect_out("max0_dn", 0, 1, 1, 1);

    // Reset beats a simultaneous load.
    rst = 1'b1;
    set_in(0, 1, 1, 0, 9, 16'h1234, 0);
    cyc();
    expect_out("rst_over_ld", 0, 0, 0, 0);
    rst = 1'b0;
`else
    set_in(0, 0, 1, 0, 9, 0, 0);
    cyc();
    set_in(1, 1, 1, 0, 9, 0, 0);
    repeat (8) cyc();
    check("ps_8cyc", 32'(bus.data_out), 2);
    repeat (2) cyc();
    set_in(1, 0, 1, 0, 9, 0, 0);
    cyc();
    set_in(1, 1, 1, 0, 9, 0, 0);
    cyc();
    check("ps_resume_pre", 32'(bus.data_out), 2);
    cyc();
    check("ps_resume", 32'(bus.data_out), 3);
    repeat (2) cyc();
    set_in(0, 1, 1, 0, 9, 5, 0);
    cyc();
    set_in(1, 1, 1, 0, 9, 0, 0);
    repeat (3) cyc();
    check("ps_restart_pre", 32'(bus.data_out), 5);
    cyc();
    check("ps_restart", 32'(bus.data_out), 6);
`endif

    // Random traffic: limits mostly small so wrap/saturate events are frequent.
    begin
      int unsigned mx;
      mx = 9;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 15) == 0)
          mx = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 16'hFFFF) : $urandom_range(0, 15);
        rst = ($urandom_range(0, 63) == 0);
        set_in($urandom_range(0, 7) != 0,
               $urandom_range(0, 3) != 0,
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               mx,
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16'hFFFF) : $urandom_range(0, 20),
               $urandom_range(0, 9) == 0);
        cyc();
      end
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
